// File: rtl/sprite_row_shifter.sv
// Double-buffered sprite row serializer: a holding word feeds an active shift register, one pixel per shift_en.
// Optional mirror support is compiled in with `define SPRITE_ROW_SHIFTER_MIRROR_EN.
module sprite_row_shifter #(
  parameter int PIX_W  = 2,
  parameter int PIXELS = 16,
  localparam int DATA_W = PIX_W * PIXELS,
  localparam int CNT_W  = $clog2(PIXELS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_mirror,
  input  logic              shift_en,
  output logic [PIX_W-1:0]  pix_out,
  output logic              pix_valid,
  output logic              pix_opaque,
  output logic              row_done,
  output logic              underrun,
  output logic [CNT_W-1:0]  remaining,
  output logic              busy
);

  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic              hold_full_q, hold_full_d;
  logic [DATA_W-1:0] act_q, act_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic [PIX_W-1:0]  pix_out_q, pix_out_d;
  logic              pix_valid_q, pix_valid_d;
  logic              row_done_q, row_done_d;
  logic              underrun_q, underrun_d;
  logic              accept, transfer, shift_ok;
  logic [DATA_W-1:0] row_word;

`ifdef SPRITE_ROW_SHIFTER_MIRROR_EN
  logic hold_mirror_q, hold_mirror_d;

  function automatic logic [DATA_W-1:0] mirror_row(input logic [DATA_W-1:0] w);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < PIXELS; i++) begin
      r[i*PIX_W +: PIX_W] = w[(PIXELS-1-i)*PIX_W +: PIX_W];
    end
    return r;
  endfunction

  // Mirroring is applied once on transfer so the active register always shifts from its low end.
  assign row_word = hold_mirror_q ? mirror_row(hold_data_q) : hold_data_q;

  always_comb begin
    hold_mirror_d = hold_mirror_q;
    if (accept) hold_mirror_d = ld_mirror;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_mirror_q <= 1'b0;
    else        hold_mirror_q <= hold_mirror_d;
  end
`else
  logic unused_mirror;
  assign unused_mirror = ld_mirror;
  assign row_word      = hold_data_q;
`endif

  assign accept   = ld_valid && !hold_full_q;
  assign shift_ok = shift_en && (remaining_q != '0);
  assign transfer = hold_full_q &&
                    ((remaining_q == '0) || ((remaining_q == CNT_W'(1)) && shift_en));

  always_comb begin
    hold_data_d = hold_data_q;
    hold_full_d = hold_full_q;
    act_d       = act_q;
    remaining_d = remaining_q;
    pix_out_d   = '0;
    pix_valid_d = 1'b0;
    row_done_d  = 1'b0;
    underrun_d  = shift_en && (remaining_q == '0);

    if (shift_ok) begin
      pix_out_d   = act_q[PIX_W-1:0];
      pix_valid_d = 1'b1;
      row_done_d  = (remaining_q == CNT_W'(1));
      act_d       = act_q >> PIX_W;
      remaining_d = remaining_q - CNT_W'(1);
    end

    // A transfer overrides the shift update; the last pixel was already captured above.
    if (transfer) begin
      act_d       = row_word;
      remaining_d = CNT_W'(PIXELS);
      hold_full_d = 1'b0;
    end

    if (accept) begin
      hold_data_d = ld_data;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_data_q <= '0;
      hold_full_q <= 1'b0;
      act_q       <= '0;
      remaining_q <= '0;
      pix_out_q   <= '0;
      pix_valid_q <= 1'b0;
      row_done_q  <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      hold_data_q <= hold_data_d;
      hold_full_q <= hold_full_d;
      act_q       <= act_d;
      remaining_q <= remaining_d;
      pix_out_q   <= pix_out_d;
      pix_valid_q <= pix_valid_d;
      row_done_q  <= row_done_d;
      underrun_q  <= underrun_d;
    end
  end

  assign ld_ready   = !hold_full_q;
  assign pix_out    = pix_out_q;
  assign pix_valid  = pix_valid_q;
  assign pix_opaque = pix_valid_q && (pix_out_q != '0);
  assign row_done   = row_done_q;
  assign underrun   = underrun_q;
  assign remaining  = remaining_q;
  assign busy       = (remaining_q != '0) || hold_full_q;

endmodule

// File: tb/tb_sprite_row_shifter.sv
// Scoreboard bench for sprite_row_shifter: loads push expected pixels, a negedge monitor pops and compares.
// Expected mirror ordering follows SPRITE_ROW_SHIFTER_MIRROR_EN.
module tb_sprite_row_shifter;

  localparam int PIX_W  = 2;
  localparam int PIXELS = 16;
  localparam int DATA_W = PIX_W * PIXELS;
  localparam int CNT_W  = $clog2(PIXELS + 1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ld_valid = 1'b0;
  logic              ld_ready;
  logic [DATA_W-1:0] ld_data = '0;
  logic              ld_mirror = 1'b0;
  logic              shift_en = 1'b0;
  logic [PIX_W-1:0]  pix_out;
  logic              pix_valid;
  logic              pix_opaque;
  logic              row_done;
  logic              underrun;
  logic [CNT_W-1:0]  remaining;
  logic              busy;

  typedef struct packed {
    logic [PIX_W-1:0] pix;
    logic             last;
  } exp_t;

  exp_t exp_q[$];

  int assert_count = 0;
  int fail_count   = 0;
  int valid_cnt    = 0;
  int done_cnt     = 0;
  int under_cnt    = 0;
  int opaque_cnt   = 0;

  sprite_row_shifter #(.PIX_W(PIX_W), .PIXELS(PIXELS)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_mirror(ld_mirror),
    .shift_en(shift_en),
    .pix_out(pix_out), .pix_valid(pix_valid), .pix_opaque(pix_opaque),
    .row_done(row_done), .underrun(underrun), .remaining(remaining), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  // Scoreboard monitor: every valid pixel must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pix_valid) begin
        valid_cnt++;
        if (pix_opaque) opaque_cnt++;
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_pixel", 32'(pix_out), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checkOutput("pix_out", 32'(pix_out), 32'(e.pix));
          checkOutput("row_done", 32'(row_done), 32'(e.last));
          checkOutput("pix_opaque", 32'(pix_opaque), 32'(e.pix != '0));
        end
      end else if (row_done) begin
        checkOutput("row_done_without_pixel", 32'(row_done), 32'd0);
      end
      if (row_done) done_cnt++;
      if (underrun) under_cnt++;
    end
  end

  task automatic pushRow(input logic [DATA_W-1:0] word, input logic mirror);
    logic m;
    int   idx;
`ifdef SPRITE_ROW_SHIFTER_MIRROR_EN
    m = mirror;
`else
    m = 1'b0;
    if (mirror) m = 1'b0;
`endif
    for (int i = 0; i < PIXELS; i++) begin
      exp_t e;
      idx    = m ? (PIXELS - 1 - i) : i;
      e.pix  = word[idx*PIX_W +: PIX_W];
      e.last = (i == PIXELS - 1);
      exp_q.push_back(e);
    end
  endtask

  // Offer a word until accepted (bounded), then push its expected pixels.
  task automatic applyStimulus(input logic [DATA_W-1:0] word, input logic mirror);
    bit done = 0;
    @(posedge clk); #1;
    ld_valid  = 1'b1;
    ld_data   = word;
    ld_mirror = mirror;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      if (ld_ready) done = 1;
      @(posedge clk); #1;
    end
    ld_valid  = 1'b0;
    ld_data   = ~word;
    ld_mirror = ~mirror;
    if (!done) checkOutput("load_accept_timeout", 32'd0, 32'd1);
    else pushRow(word, mirror);
  endtask

  task automatic waitLoaded();
    bit done = 0;
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge clk);
      if (remaining == CNT_W'(PIXELS)) done = 1;
    end
    checkOutput("remaining_start", 32'(remaining), PIXELS);
  endtask

  task automatic shiftFor(input int n);
    @(posedge clk); #1;
    shift_en = 1'b1;
    repeat (n) @(posedge clk);
    #1 shift_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int v0, d0, u0, o0;

  initial begin
    $display("[TB] starting sprite_row_shifter bench");

    // Reset values while rst_n is held low, with inputs active to show they are ignored.
    ld_valid = 1'b1; ld_data = 32'h1234_5678; shift_en = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_pix_out", 32'(pix_out), 32'd0);
    checkOutput("rst_pix_valid", 32'(pix_valid), 32'd0);
    checkOutput("rst_row_done", 32'(row_done), 32'd0);
    checkOutput("rst_underrun", 32'(underrun), 32'd0);
    checkOutput("rst_remaining", 32'(remaining), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_ld_ready", 32'(ld_ready), 32'd1);
    ld_valid = 1'b0; shift_en = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;

    // Underrun with nothing loaded.
    @(posedge clk); #1 shift_en = 1'b1;
    @(posedge clk); #1 shift_en = 1'b0;
    @(negedge clk);
    checkOutput("underrun_pulse", 32'(underrun), 32'd1);
    checkOutput("underrun_pix_valid", 32'(pix_valid), 32'd0);
    checkOutput("underrun_pix_out", 32'(pix_out), 32'd0);
    checkOutput("underrun_remaining", 32'(remaining), 32'd0);
    @(negedge clk);
    checkOutput("underrun_one_cycle", 32'(underrun), 32'd0);

    // Plain row, pixels 0,1,2,3 repeating.
    d0 = done_cnt;
    applyStimulus(32'hE4E4_E4E4, 1'b0);
    waitLoaded();
    shiftFor(16);
    idle(2);
    checkOutput("row0_remaining_end", 32'(remaining), 32'd0);
    checkOutput("row0_row_done_count", 32'(done_cnt - d0), 32'd1);
    checkOutput("row0_queue_empty", 32'(exp_q.size()), 32'd0);
    checkOutput("row0_busy_end", 32'(busy), 32'd0);

    // Mirror request: reversed only when the feature is built in.
    applyStimulus(32'hE4E4_E4E4, 1'b1);
    waitLoaded();
    shiftFor(16);
    idle(2);
    checkOutput("mirror_queue_empty", 32'(exp_q.size()), 32'd0);

    // Back-to-back rows with no gap between them.
    v0 = valid_cnt; d0 = done_cnt; u0 = under_cnt;
    applyStimulus(32'h5555_5555, 1'b0);
    applyStimulus(32'hAAAA_AAAA, 1'b0);
    @(negedge clk);
    checkOutput("b2b_ld_ready_low", 32'(ld_ready), 32'd0);
    checkOutput("b2b_remaining", 32'(remaining), PIXELS);
    checkOutput("b2b_busy", 32'(busy), 32'd1);
    shiftFor(32);
    idle(2);
    checkOutput("b2b_valid_count", 32'(valid_cnt - v0), 32'd32);
    checkOutput("b2b_row_done_count", 32'(done_cnt - d0), 32'd2);
    checkOutput("b2b_underrun_count", 32'(under_cnt - u0), 32'd0);
    checkOutput("b2b_ld_ready_end", 32'(ld_ready), 32'd1);

    // Opaque only on the first four pixels.
    o0 = opaque_cnt;
    applyStimulus(32'h0000_00FF, 1'b0);
    waitLoaded();
    shiftFor(16);
    idle(2);
    checkOutput("opaque_count", 32'(opaque_cnt - o0), 32'd4);

    // Reset mid-row with the holding buffer full.
    applyStimulus(32'hE4E4_E4E4, 1'b0);
    applyStimulus(32'h0000_00FF, 1'b0);
    shiftFor(5);
    @(negedge clk);
    d0 = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_pix_out", 32'(pix_out), 32'd0);
    checkOutput("midrst_pix_valid", 32'(pix_valid), 32'd0);
    checkOutput("midrst_row_done", 32'(row_done), 32'd0);
    checkOutput("midrst_underrun", 32'(underrun), 32'd0);
    checkOutput("midrst_remaining", 32'(remaining), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_ld_ready", 32'(ld_ready), 32'd1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(3);
    checkOutput("midrst_no_row_done", 32'(done_cnt - d0), 32'd0);
    checkOutput("midrst_remaining_after", 32'(remaining), 32'd0);
    checkOutput("midrst_ld_ready_after", 32'(ld_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/sprite_row_shifter.md
SPRITE_ROW_SHIFTER -- requirements
Module: sprite_row_shifter

Interface
REQ-001 SHALL have parameter PIX_W, default 2, bits per sprite pixel.
REQ-002 SHALL have parameter PIXELS, default 16, pixels per sprite row word; DATA_W = PIX_W*PIXELS; CNT_W = $clog2(PIXELS+1).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port ld_valid  input  1  row word offered.
REQ-006 SHALL have port ld_ready  output  1  holding buffer empty, word may be accepted.
REQ-007 SHALL have port ld_data  input  DATA_W  row word; pixel i = ld_data[i*PIX_W +: PIX_W].
REQ-008 SHALL have port ld_mirror  input  1  sampled with ld_data; 1 = shift pixel PIXELS-1 first.
REQ-009 SHALL have port shift_en  input  1  request one pixel this cycle.
REQ-010 SHALL have port pix_out  output  PIX_W  registered pixel.
REQ-011 SHALL have port pix_valid  output  1  pix_out holds a real pixel this cycle.
REQ-012 SHALL have port pix_opaque  output  1  pix_valid and pix_out != 0 (pixel value 0 = transparent).
REQ-013 SHALL have port row_done  output  1  one-cycle pulse coincident with the last pixel of a row.
REQ-014 SHALL have port underrun  output  1  one-cycle pulse: shift_en with no pixel available.
REQ-015 SHALL have port remaining  output  CNT_W  pixels left in the active register.
REQ-016 SHALL have port busy  output  1  remaining != 0 or holding buffer full.

Function
REQ-017 SHALL hold two row buffers: holding (word, mirror flag, full bit) and active (shift register, remaining counter).
REQ-018 SHALL drive ld_ready = not holding-full; a word is accepted on a clock edge where ld_valid and ld_ready are both 1.
REQ-019 SHALL hold ld_data/ld_mirror stable-independent: the accepted word is captured on the accept edge and later input changes have no effect.
REQ-020 SHALL transfer holding into active on an edge where holding is full and (remaining == 0, or remaining == 1 and shift_en = 1); remaining becomes PIXELS and holding-full clears.
REQ-021 SHALL, on remaining == 1 with shift_en and holding full, emit the last pixel and load the next row on the same edge (no bubble between rows).
REQ-022 SHALL NOT transfer on the edge a word is accepted into an empty holding buffer; earliest transfer is the following edge (accept-to-first-pixel-valid minimum 3 edges).
REQ-023 SHALL, on shift_en with remaining > 0, register the next pixel into pix_out, set pix_valid = 1, decrement remaining; pix_out is valid the cycle after shift_en is sampled.
REQ-024 SHALL output pixels in order 0,1,...,PIXELS-1 when mirror = 0 and PIXELS-1,...,0 when mirror = 1 (REQ-044).
REQ-025 SHALL assert row_done in the same cycle as pix_valid for the pixel that takes remaining from 1 to 0.
REQ-026 SHALL, on shift_en with remaining == 0, drive pix_out = 0, pix_valid = 0, underrun = 1 for one cycle; no state change besides any REQ-020 transfer.
REQ-027 SHALL, with shift_en = 0, drive pix_out = 0, pix_valid = 0 next cycle, and hold the active register and remaining.
REQ-028 SHALL allow accept and transfer on the same edge only when holding was already full and frees that edge; ld_ready is registered-state-derived, so no combinational path from shift_en to ld_ready.
REQ-029 SHALL compute pix_opaque combinationally from registered pix_out and pix_valid.

Reset
REQ-030 SHALL, while rst_n = 0, force pix_out = 0, pix_valid = 0, row_done = 0, underrun = 0, remaining = 0, holding-full = 0, active register = 0, busy = 0, ld_ready = 1.
REQ-031 SHALL ignore ld_valid and shift_en while rst_n = 0.
REQ-032 SHALL discard any partially shifted row and any held word on reset assertion mid-operation; no row_done is emitted for it.

Configuration
REQ-040 SHALL use macro SPRITE_ROW_SHIFTER_MIRROR_EN to include mirror support.
REQ-041 SHALL, with the macro defined, store ld_mirror with the held word and apply it per row per REQ-024.
REQ-042 SHALL, without the macro, ignore ld_mirror and always output pixel 0 first.
REQ-043 SHALL keep port list identical in both builds.
REQ-044 SHALL treat REQ-024 mirror ordering as present only when the macro is defined.

Verification
REQ-050 SHALL cover: PIX_W=2, PIXELS=16, load 0xE4E4_E4E4 mirror=0, shift_en held 16 cycles -> pix_out 0,1,2,3 repeating, row_done on 16th pixel, remaining 16->0.
REQ-051 SHALL cover: same word with mirror=1 (macro defined) -> pix_out 3,2,1,0 repeating; macro undefined -> 0,1,2,3.
REQ-052 SHALL cover: two words 0x5555_5555 then 0xAAAA_AAAA back-to-back, shift_en held 32 cycles -> 16x1 then 16x2 with no gap, two row_done pulses, ld_ready low while holding full.
REQ-053 SHALL cover: shift_en with nothing loaded after reset -> underrun = 1, pix_valid = 0, pix_out = 0, remaining = 0.
REQ-054 SHALL cover: word 0x0000_00FF, shift_en 16 cycles -> pix_opaque high for pixels 0-3 only.
REQ-055 SHALL cover: rst_n low after 5 pixels shifted with holding full -> all outputs per REQ-030 asynchronously, no row_done, ld_ready = 1.
